// File: rtl/rs_issue_arbiter_pkg.sv
// Shared payload layout and slot state encoding for the RS issue arbiter.
// RS units and Execute pack/unpack the issue payload through rs_payload_t.
package rs_issue_arbiter_pkg;

  localparam int DATA_LEN         = 32;
  localparam int ADDR_LEN         = 32;
  localparam int RRF_SEL          = 6;
  localparam int ALU_OP_WIDTH     = 4;
  localparam int RS_ISSUE_REQ_NUM = 2;

  localparam int RS_PAYLOAD_W = 3*DATA_LEN + ADDR_LEN + RRF_SEL + 1 + ALU_OP_WIDTH;

  typedef struct packed {
    logic [DATA_LEN-1:0]     op1;
    logic [DATA_LEN-1:0]     op2;
    logic [ADDR_LEN-1:0]     pc;
    logic [DATA_LEN-1:0]     imm;
    logic [RRF_SEL-1:0]      tag;
    logic                    dst;
    logic [ALU_OP_WIDTH-1:0] alu_op;
  } rs_payload_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rs_issue_arbiter_if.sv
// Bundle between the RS issue ports / Execute and the issue arbiter.
// RS_ISSUE_ARB_PERF_EN adds the performance counter outputs.
interface rs_issue_arbiter_if
  import rs_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = RS_ISSUE_REQ_NUM,
  parameter int REQ_SEL   = $clog2(NUM_REQ),
  parameter int PAYLOAD_W = RS_PAYLOAD_W
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*PAYLOAD_W-1:0] payload;
  logic [NUM_REQ-1:0]           grant;
  logic                         kill;
  logic                         exe_ready;
  logic                         exe_valid;
  logic [PAYLOAD_W-1:0]         exe_payload;
  logic [REQ_SEL-1:0]           exe_src;
`ifdef RS_ISSUE_ARB_PERF_EN
  logic [NUM_REQ*32-1:0]        perf_grant_cnt;
  logic [31:0]                  perf_stall_cnt;

  modport master (output req, payload, kill, exe_ready,
                  input  grant, exe_valid, exe_payload, exe_src, perf_grant_cnt, perf_stall_cnt);
  modport slave  (input  req, payload, kill, exe_ready,
                  output grant, exe_valid, exe_payload, exe_src, perf_grant_cnt, perf_stall_cnt);
`else
  modport master (output req, payload, kill, exe_ready,
                  input  grant, exe_valid, exe_payload, exe_src);
  modport slave  (input  req, payload, kill, exe_ready,
                  output grant, exe_valid, exe_payload, exe_src);
`endif
endinterface

// File: rtl/rs_issue_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: first set req bit at or above ptr, wrapping.
// Kept generic so MUL/LSU issue ports can reuse it.
module rs_issue_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int REQ_SEL = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_SEL-1:0] ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [REQ_SEL-1:0] idx
);

  logic               found;
  int                 cand_w;
  logic [REQ_SEL-1:0] cand;

  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    cand_w = 0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_w = int'(ptr) + off;
      if (cand_w >= NUM_REQ) cand_w = cand_w - NUM_REQ;
      cand = REQ_SEL'(cand_w);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/rs_issue_arbiter.sv
// Round-robin issue arbiter feeding a one-entry slot in front of the ALU execute pipe.
// Optional RS_ISSUE_ARB_PERF_EN adds grant/stall performance counters.
module rs_issue_arbiter
  import rs_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = RS_ISSUE_REQ_NUM,
  parameter int REQ_SEL   = $clog2(NUM_REQ),
  parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  rs_issue_arbiter_if.slave bus
);

  slot_state_e          state_q, state_d;
  logic [REQ_SEL-1:0]   rr_ptr_q;
  logic [REQ_SEL-1:0]   grant_idx_p0;
  logic [NUM_REQ-1:0]   grant_p0;
  logic                 can_issue;
  logic                 any_grant;
  logic [PAYLOAD_W-1:0] sel_payload_p0;
  logic                 vld_p1;
  logic [PAYLOAD_W-1:0] payload_p1;
  logic [REQ_SEL-1:0]   src_p1;

  // Stage p0: select. Nothing is granted while in reset so no RS entry is cleared.
  assign can_issue = ~reset_i & ~bus.kill & (~vld_p1 | bus.exe_ready);

  rs_issue_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .REQ_SEL(REQ_SEL)
  ) u_rr_arbiter (
    .req  (bus.req),
    .ptr  (rr_ptr_q),
    .en   (can_issue),
    .grant(grant_p0),
    .idx  (grant_idx_p0)
  );

  assign any_grant = |grant_p0;
  assign bus.grant = grant_p0;

  always_comb begin
    sel_payload_p0 = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant_p0[n]) sel_payload_p0 = bus.payload[n*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Slot FSM: state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= SLOT_EMPTY;
    else         state_q <= state_d;
  end

  // Slot FSM: next state; kill overrides both drain and a new grant
  always_comb begin
    state_d = state_q;
    if (bus.kill)                                state_d = SLOT_EMPTY;
    else if (any_grant)                          state_d = SLOT_FULL;
    else if (state_q == SLOT_FULL && bus.exe_ready) state_d = SLOT_EMPTY;
  end

  // Slot FSM: outputs
  always_comb begin
    vld_p1 = (state_q == SLOT_FULL);
  end

  // Stage p1: issue slot. Payload is deliberately left in place on drain/kill.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      payload_p1 <= '0;
      src_p1     <= '0;
      rr_ptr_q   <= '0;
    end else if (any_grant) begin
      payload_p1 <= sel_payload_p0;
      src_p1     <= grant_idx_p0;
      rr_ptr_q   <= (grant_idx_p0 == REQ_SEL'(NUM_REQ-1)) ? '0 : grant_idx_p0 + REQ_SEL'(1);
    end
  end

  assign bus.exe_valid   = vld_p1;
  assign bus.exe_payload = payload_p1;
  assign bus.exe_src     = src_p1;

`ifdef RS_ISSUE_ARB_PERF_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int n = 0; n < NUM_REQ; n++) grant_cnt_q[n] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int n = 0; n < NUM_REQ; n++) begin
        if (grant_p0[n]) grant_cnt_q[n] <= grant_cnt_q[n] + 32'd1;
      end
      if (vld_p1 && !bus.exe_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    bus.perf_grant_cnt = '0;
    for (int n = 0; n < NUM_REQ; n++) bus.perf_grant_cnt[n*32 +: 32] = grant_cnt_q[n];
  end
  assign bus.perf_stall_cnt = stall_cnt_q;
`endif

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_p0));
  a_grant_req:    assert property (@(posedge clk_i) disable iff (reset_i) (grant_p0 & ~bus.req) == '0);

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Directed bench for rs_issue_arbiter: vector table on a 2-port instance plus
// hand sequences for 3-port wrap-around and (when enabled) perf counters.
module tb_rs_issue_arbiter;
  import rs_issue_arbiter_pkg::*;

  localparam int PW = RS_PAYLOAD_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic rst3 = 1'b1;

  rs_issue_arbiter_if #(.NUM_REQ(2), .REQ_SEL(1), .PAYLOAD_W(PW)) bus ();
  rs_issue_arbiter_if #(.NUM_REQ(3), .REQ_SEL(2), .PAYLOAD_W(PW)) bus3 ();

  rs_issue_arbiter #(.NUM_REQ(2), .REQ_SEL(1), .PAYLOAD_W(PW)) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus));

  rs_issue_arbiter #(.NUM_REQ(3), .REQ_SEL(2), .PAYLOAD_W(PW)) dut3 (
    .clk_i(clk), .reset_i(rst3), .bus(bus3));

  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic          kill;
    logic          rdy;
    logic [PW-1:0] p0;
    logic [PW-1:0] p1;
    logic [1:0]    exp_grant;
    logic          chk_state;
    logic          exp_valid;
    logic          exp_src;
    logic [PW-1:0] exp_payload;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [1:0] req, input logic k, input logic rdy,
                              input int p0, input int p1, input logic [1:0] g,
                              input logic cs, input logic v, input logic s, input int pay);
    vec_t t;
    t.rst = r; t.req = req; t.kill = k; t.rdy = rdy;
    t.p0 = PW'(p0); t.p1 = PW'(p1);
    t.exp_grant = g; t.chk_state = cs; t.exp_valid = v; t.exp_src = s;
    t.exp_payload = PW'(pay);
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic r, input logic [1:0] req, input logic k, input logic rdy,
                       input int p0, input int p1);
    @(posedge clk);
    #1;
    rst = r; bus.req = req; bus.kill = k; bus.exe_ready = rdy;
    bus.payload = {PW'(p1), PW'(p0)};
    #3;
  endtask

  initial begin
    bus.req = '0; bus.kill = 1'b0; bus.exe_ready = 1'b1; bus.payload = '0;
    bus3.req = '0; bus3.kill = 1'b0; bus3.exe_ready = 1'b1; bus3.payload = '0;

    //   rst req    kill rdy  p0     p1     grant  chk v  src payload
    add(1, 2'b11, 0, 1, 'h111, 'h222, 2'b00, 0, 0, 0, 0);      // reset, state not yet defined
    add(1, 2'b11, 0, 1, 'h111, 'h222, 2'b00, 1, 0, 0, 0);
    add(0, 2'b11, 0, 1, 'h111, 'h222, 2'b01, 1, 0, 0, 0);      // first grant after release
    add(0, 2'b11, 0, 1, 'h111, 'h222, 2'b10, 1, 1, 0, 'h111);  // fairness alternation
    add(0, 2'b11, 0, 1, 'h111, 'h222, 2'b01, 1, 1, 1, 'h222);
    add(0, 2'b11, 0, 1, 'h111, 'h222, 2'b10, 1, 1, 0, 'h111);
    add(0, 2'b11, 0, 1, 'h111, 'h222, 2'b01, 1, 1, 1, 'h222);
    add(0, 2'b11, 0, 1, 'h111, 'h222, 2'b10, 1, 1, 0, 'h111);
    add(0, 2'b10, 0, 0, 'h111, 'h333, 2'b00, 1, 1, 1, 'h222);  // backpressure
    add(0, 2'b10, 0, 0, 'h111, 'h333, 2'b00, 1, 1, 1, 'h222);
    add(0, 2'b10, 0, 0, 'h111, 'h333, 2'b00, 1, 1, 1, 'h222);
    add(0, 2'b10, 0, 1, 'h111, 'h333, 2'b10, 1, 1, 1, 'h222);  // drain + grant same cycle
    add(0, 2'b00, 0, 1, 'h111, 'h333, 2'b00, 1, 1, 1, 'h333);
    add(0, 2'b00, 0, 1, 'h111, 'h333, 2'b00, 1, 0, 1, 'h333);  // drained, payload kept
    add(0, 2'b01, 0, 0, 'h444, 'h333, 2'b01, 1, 0, 1, 'h333);
    add(0, 2'b01, 1, 0, 'h444, 'h333, 2'b00, 1, 1, 0, 'h444);  // kill while full
    add(0, 2'b11, 0, 1, 'h444, 'h222, 2'b10, 1, 0, 0, 'h444);  // ptr kept at 1 across kill
    add(0, 2'b01, 0, 0, 'h555, 'h222, 2'b00, 1, 1, 1, 'h222);
    add(1, 2'b11, 1, 0, 'h555, 'h222, 2'b00, 1, 1, 1, 'h222);  // reset mid-operation
    add(0, 2'b11, 0, 0, 'h666, 'h222, 2'b01, 1, 0, 0, 0);
    add(0, 2'b00, 0, 1, 'h666, 'h222, 2'b00, 1, 1, 0, 'h666);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].kill, vecs[i].rdy, int'(vecs[i].p0), int'(vecs[i].p1));
      chk($sformatf("v%0d grant", i), 160'(bus.grant), 160'(vecs[i].exp_grant));
      if (vecs[i].chk_state) begin
        chk($sformatf("v%0d valid", i), 160'(bus.exe_valid), 160'(vecs[i].exp_valid));
        chk($sformatf("v%0d src", i), 160'(bus.exe_src), 160'(vecs[i].exp_src));
        chk($sformatf("v%0d payload", i), 160'(bus.exe_payload), 160'(vecs[i].exp_payload));
      end
    end

    // 3-port wrap: grant req1 to move ptr to 2, then 3'b011 must wrap to req0.
    @(posedge clk); #1;
    rst3 = 1'b0; bus3.req = 3'b010; bus3.exe_ready = 1'b1;
    bus3.payload = {PW'('hC3), PW'('hB2), PW'('hA1)};
    #3;
    chk("wrap grant1", 160'(bus3.grant), 160'(3'b010));
    @(posedge clk); #1;
    bus3.req = 3'b011;
    #3;
    chk("wrap grant0", 160'(bus3.grant), 160'(3'b001));
    chk("wrap src1", 160'(bus3.exe_src), 160'(2'd1));
    chk("wrap pay1", 160'(bus3.exe_payload), 160'('hB2));
    @(posedge clk); #1;
    #3;
    chk("wrap ptr1", 160'(bus3.grant), 160'(3'b010));
    chk("wrap src0", 160'(bus3.exe_src), 160'(2'd0));
    chk("wrap pay0", 160'(bus3.exe_payload), 160'('hA1));

`ifdef RS_ISSUE_ARB_PERF_EN
    drive(1, 2'b00, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 2'b10, 0, 1, 0, 'h700 + k);
    for (int k = 0; k < 4; k++) drive(0, 2'b00, 0, 0, 0, 0);
    drive(0, 2'b01, 1, 1, 'h800, 0);
    chk("perf grant1", 160'(bus.perf_grant_cnt[63:32]), 160'(32'd5));
    chk("perf grant0", 160'(bus.perf_grant_cnt[31:0]), 160'(32'd0));
    chk("perf stall", 160'(bus.perf_stall_cnt), 160'(32'd4));
    drive(0, 2'b00, 0, 1, 0, 0);
    chk("perf kill valid", 160'(bus.exe_valid), 160'(1'b0));
    chk("perf grant1 kill", 160'(bus.perf_grant_cnt[63:32]), 160'(32'd5));
    chk("perf stall kill", 160'(bus.perf_stall_cnt), 160'(32'd4));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
